cmd_update_sync: RTL and testbench

- Parametrised successor of the command update block.
- Captures depacketised commands into a shadow bank on update_cmd. Applies them to the active outputs only on the next PRF rising edge, so parameter changes never land mid-pulse.
- After an apply, waits a settle time before issuing the AD9914 sweep.
- Generalises the receive-channel count, attenuator/phase widths and FTW segment count. Flags command overruns.

---
 rtl/cmd_update_pkg.sv | 30 +++
 rtl/cmd_shadow_bank.sv | 96 +++++++++
 rtl/cmd_update_sync.sv | 177 +++++++++++++++++
 tb/tb_cmd_update_sync.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_update_pkg.sv
// Shared encodings for the command update block: modes, edge codes, FSM states.
// Pure definitions; no latency or flow control.
package cmd_update_pkg;

    localparam logic [2:0] MODE_SINGLE   = 3'b000;
    localparam logic [2:0] MODE_DUAL_TVH = 3'b010;
    localparam logic [2:0] MODE_DUAL     = 3'b011;
    localparam logic [2:0] MODE_ALL      = 3'b100;

    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SWEEP
    } state_t;

    // Low n bits set, for channel enable masks of up to 8 channels.
    function automatic logic [7:0] low_mask(input int unsigned n);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cmd_shadow_bank.sv
// Shadow/active register pair: capture writes the shadow (att/pha truncated to ATT_W), apply copies it to active.
// One-cycle registered update on each strobe; no backpressure, capture and apply may coincide (apply takes the old shadow).
module cmd_shadow_bank
    import cmd_update_pkg::*;
#(
    parameter int NUM_RX_CH = 3,
    parameter int ATT_W     = 6,
    parameter int NUM_SEG   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture,
    input  logic                       apply,
    input  logic [2:0]                 depack_mode,
    input  logic                       depack_rf_switch,
    input  logic [5:0]                 depack_tx_att,
    input  logic [8*NUM_RX_CH-1:0]     depack_rx_att,
    input  logic [8*NUM_RX_CH-1:0]     depack_rx_pha,
    input  logic [32*NUM_SEG-1:0]      depack_ftw_lower,
    input  logic [32*NUM_SEG-1:0]      depack_ftw_upper,
    input  logic [31:0]                depack_sweep_step,
    input  logic [15:0]                depack_sweep_rate,
    output logic [2:0]                 act_mode,
    output logic                       act_rf_switch,
    output logic [5:0]                 act_tx_att,
    output logic [ATT_W*NUM_RX_CH-1:0] act_rx_att,
    output logic [ATT_W*NUM_RX_CH-1:0] act_rx_pha,
    output logic [32*NUM_SEG-1:0]      act_ftw_lower,
    output logic [32*NUM_SEG-1:0]      act_ftw_upper,
    output logic [31:0]                act_sweep_step,
    output logic [15:0]                act_sweep_rate
);

    logic [2:0]                 sh_mode;
    logic                       sh_rf_switch;
    logic [5:0]                 sh_tx_att;
    logic [ATT_W*NUM_RX_CH-1:0] sh_rx_att;
    logic [ATT_W*NUM_RX_CH-1:0] sh_rx_pha;
    logic [32*NUM_SEG-1:0]      sh_ftw_lower;
    logic [32*NUM_SEG-1:0]      sh_ftw_upper;
    logic [31:0]                sh_sweep_step;
    logic [15:0]                sh_sweep_rate;

    // Bits above ATT_W in each 8-bit field are dropped on capture.
    logic unused_att_bits;
    assign unused_att_bits = ^{depack_rx_att, depack_rx_pha};

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode        <= MODE_SINGLE;
            sh_rf_switch   <= 1'b0;
            sh_tx_att      <= '0;
            sh_rx_att      <= '0;
            sh_rx_pha      <= '0;
            sh_ftw_lower   <= '0;
            sh_ftw_upper   <= '0;
            sh_sweep_step  <= '0;
            sh_sweep_rate  <= '0;
            act_mode       <= MODE_SINGLE;
            act_rf_switch  <= 1'b0;
            act_tx_att     <= '0;
            act_rx_att     <= '0;
            act_rx_pha     <= '0;
            act_ftw_lower  <= '0;
            act_ftw_upper  <= '0;
            act_sweep_step <= '0;
            act_sweep_rate <= '0;
        end else begin
            if (apply) begin
                act_mode       <= sh_mode;
                act_rf_switch  <= sh_rf_switch;
                act_tx_att     <= sh_tx_att;
                act_rx_att     <= sh_rx_att;
                act_rx_pha     <= sh_rx_pha;
                act_ftw_lower  <= sh_ftw_lower;
                act_ftw_upper  <= sh_ftw_upper;
                act_sweep_step <= sh_sweep_step;
                act_sweep_rate <= sh_sweep_rate;
            end
            if (capture) begin
                sh_mode       <= depack_mode;
                sh_rf_switch  <= depack_rf_switch;
                sh_tx_att     <= depack_tx_att;
                sh_ftw_lower  <= depack_ftw_lower;
                sh_ftw_upper  <= depack_ftw_upper;
                sh_sweep_step <= depack_sweep_step;
                sh_sweep_rate <= depack_sweep_rate;
                for (int i = 0; i < NUM_RX_CH; i++) begin
                    sh_rx_att[i*ATT_W +: ATT_W] <= depack_rx_att[i*8 +: ATT_W];
                    sh_rx_pha[i*ATT_W +: ATT_W] <= depack_rx_pha[i*8 +: ATT_W];
                end
            end
        end
    end

endmodule

// File: rtl/cmd_update_sync.sv
// Applies shadowed commands on the next PRF rise, then issues the AD9914 sweep SETTLE_CYC cycles after the load.
// Strobes register in one cycle; no backpressure, a second command before apply overwrites the shadow and flags overrun.
module cmd_update_sync
    import cmd_update_pkg::*;
#(
    parameter int NUM_RX_CH  = 3,
    parameter int ATT_W      = 6,
    parameter int NUM_SEG    = 2,
    parameter int SETTLE_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       update_cmd,
    input  logic [1:0]                 tr_edge,
    input  logic [1:0]                 prf_edge,
    input  logic                       ct,
    input  logic [2:0]                 depack_mode,
    input  logic                       depack_rf_switch,
    input  logic [5:0]                 depack_tx_att,
    input  logic [8*NUM_RX_CH-1:0]     depack_rx_att,
    input  logic [8*NUM_RX_CH-1:0]     depack_rx_pha,
    input  logic [32*NUM_SEG-1:0]      depack_ftw_lower,
    input  logic [32*NUM_SEG-1:0]      depack_ftw_upper,
    input  logic [31:0]                depack_sweep_step,
    input  logic [15:0]                depack_sweep_rate,
    output logic                       ad9914_load,
    output logic                       ad9914_sweep,
    output logic                       rx_att_load,
    output logic                       rf_switch,
    output logic                       rf_power,
    output logic                       ct_switch,
    output logic                       tvh,
    output logic [NUM_RX_CH-1:0]       rx_ch_pwr_ctrl,
    output logic [NUM_RX_CH-1:0]       rx_ch_ctrl,
    output logic [5:0]                 tx_att,
    output logic [ATT_W*NUM_RX_CH-1:0] rx_att,
    output logic [ATT_W*NUM_RX_CH-1:0] rx_pha,
    output logic [32*NUM_SEG-1:0]      ftw_lower,
    output logic [32*NUM_SEG-1:0]      ftw_upper,
    output logic [31:0]                sweep_step,
    output logic [15:0]                sweep_rate,
    output logic                       cmd_pending,
    output logic                       cmd_overrun
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam int unsigned DUAL_N = (NUM_RX_CH < 2) ? NUM_RX_CH : 2;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           act_mode;
    logic                 act_rf_switch;
    logic [NUM_RX_CH-1:0] ch_mask;
    logic                 ct_switch_q;
    logic                 rf_power_q;
    logic                 tvh_q;
    logic                 prf_rise;
    logic                 tr_fall;
    logic                 apply_now;

    assign prf_rise  = (prf_edge == EDGE_RISE);
    assign tr_fall   = (tr_edge == EDGE_FALL);
    assign apply_now = (state == ST_IDLE) && prf_rise && cmd_pending;

    cmd_shadow_bank #(
        .NUM_RX_CH (NUM_RX_CH),
        .ATT_W     (ATT_W),
        .NUM_SEG   (NUM_SEG)
    ) u_bank (
        .clk               (clk),
        .rst               (rst),
        .capture           (update_cmd),
        .apply             (apply_now),
        .depack_mode       (depack_mode),
        .depack_rf_switch  (depack_rf_switch),
        .depack_tx_att     (depack_tx_att),
        .depack_rx_att     (depack_rx_att),
        .depack_rx_pha     (depack_rx_pha),
        .depack_ftw_lower  (depack_ftw_lower),
        .depack_ftw_upper  (depack_ftw_upper),
        .depack_sweep_step (depack_sweep_step),
        .depack_sweep_rate (depack_sweep_rate),
        .act_mode          (act_mode),
        .act_rf_switch     (act_rf_switch),
        .act_tx_att        (tx_att),
        .act_rx_att        (rx_att),
        .act_rx_pha        (rx_pha),
        .act_ftw_lower     (ftw_lower),
        .act_ftw_upper     (ftw_upper),
        .act_sweep_step    (sweep_step),
        .act_sweep_rate    (sweep_rate)
    );

    // The counter holds SETTLE_CYC-1 during the load cycle, so the sweep lands exactly SETTLE_CYC cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ad9914_load  <= 1'b0;
            rx_att_load  <= 1'b0;
            ad9914_sweep <= 1'b0;
            cmd_pending  <= 1'b0;
            cmd_overrun  <= 1'b0;
        end else begin
            ad9914_load  <= 1'b0;
            rx_att_load  <= 1'b0;
            ad9914_sweep <= 1'b0;
            cmd_overrun  <= update_cmd && cmd_pending && !apply_now;

            if (apply_now)       cmd_pending <= update_cmd;
            else if (update_cmd) cmd_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (prf_rise) begin
                        if (cmd_pending) begin
                            state       <= ST_APPLY;
                            cnt         <= CNT_LOAD;
                            ad9914_load <= 1'b1;
                            rx_att_load <= 1'b1;
                        end else begin
                            state        <= ST_SWEEP;
                            ad9914_sweep <= 1'b1;
                        end
                    end
                end
                ST_APPLY, ST_SETTLE: begin
                    if (cnt == '0) begin
                        state        <= ST_SWEEP;
                        ad9914_sweep <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                ST_SWEEP: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Unlisted modes keep the previous mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_mask <= NUM_RX_CH'(low_mask(1));
        end else begin
            case (act_mode)
                MODE_SINGLE:             ch_mask <= NUM_RX_CH'(low_mask(1));
                MODE_DUAL_TVH, MODE_DUAL: ch_mask <= NUM_RX_CH'(low_mask(DUAL_N));
                MODE_ALL:                ch_mask <= NUM_RX_CH'(low_mask(NUM_RX_CH));
                default:                 ch_mask <= ch_mask;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_switch_q <= 1'b1;
            rf_power_q  <= 1'b0;
            tvh_q       <= 1'b0;
        end else begin
            if (prf_rise)     ct_switch_q <= ~ct;
            if (prf_rise)     rf_power_q  <= 1'b1;
            else if (tr_fall) rf_power_q  <= 1'b0;
            if (tr_fall)      tvh_q       <= (act_mode == MODE_DUAL_TVH) ? ~tvh_q : 1'b0;
        end
    end

    assign ct_switch      = ct_switch_q;
    assign rf_switch      = ct_switch_q ? ~act_rf_switch : 1'b1;
    assign rf_power       = rf_power_q & act_rf_switch;
    assign tvh            = tvh_q;
    assign rx_ch_pwr_ctrl = ch_mask;
    assign rx_ch_ctrl     = ct_switch_q ? ch_mask : '0;

endmodule

// File: tb/tb_cmd_update_sync.sv
// Directed bench for cmd_update_sync at default parameters (3 channels, 6-bit att, 2 segments, settle 8).
module tb_cmd_update_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        update_cmd;
    logic [1:0]  tr_edge;
    logic [1:0]  prf_edge;
    logic        ct;
    logic [2:0]  depack_mode;
    logic        depack_rf_switch;
    logic [5:0]  depack_tx_att;
    logic [23:0] depack_rx_att;
    logic [23:0] depack_rx_pha;
    logic [63:0] depack_ftw_lower;
    logic [63:0] depack_ftw_upper;
    logic [31:0] depack_sweep_step;
    logic [15:0] depack_sweep_rate;
    logic        ad9914_load, ad9914_sweep, rx_att_load;
    logic        rf_switch, rf_power, ct_switch, tvh;
    logic [2:0]  rx_ch_pwr_ctrl, rx_ch_ctrl;
    logic [5:0]  tx_att;
    logic [17:0] rx_att, rx_pha;
    logic [63:0] ftw_lower, ftw_upper;
    logic [31:0] sweep_step;
    logic [15:0] sweep_rate;
    logic        cmd_pending, cmd_overrun;

    int checks = 0;
    int errors = 0;

    cmd_update_sync dut (
        .clk               (clk),
        .rst               (rst),
        .update_cmd        (update_cmd),
        .tr_edge           (tr_edge),
        .prf_edge          (prf_edge),
        .ct                (ct),
        .depack_mode       (depack_mode),
        .depack_rf_switch  (depack_rf_switch),
        .depack_tx_att     (depack_tx_att),
        .depack_rx_att     (depack_rx_att),
        .depack_rx_pha     (depack_rx_pha),
        .depack_ftw_lower  (depack_ftw_lower),
        .depack_ftw_upper  (depack_ftw_upper),
        .depack_sweep_step (depack_sweep_step),
        .depack_sweep_rate (depack_sweep_rate),
        .ad9914_load       (ad9914_load),
        .ad9914_sweep      (ad9914_sweep),
        .rx_att_load       (rx_att_load),
        .rf_switch         (rf_switch),
        .rf_power          (rf_power),
        .ct_switch         (ct_switch),
        .tvh               (tvh),
        .rx_ch_pwr_ctrl    (rx_ch_pwr_ctrl),
        .rx_ch_ctrl        (rx_ch_ctrl),
        .tx_att            (tx_att),
        .rx_att            (rx_att),
        .rx_pha            (rx_pha),
        .ftw_lower         (ftw_lower),
        .ftw_upper         (ftw_upper),
        .sweep_step        (sweep_step),
        .sweep_rate        (sweep_rate),
        .cmd_pending       (cmd_pending),
        .cmd_overrun       (cmd_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic send_cmd();
        update_cmd = 1'b1;
        tick();
        update_cmd = 1'b0;
    endtask

    task automatic prf_rise();
        prf_edge = 2'b01;
        tick();
        prf_edge = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (rf_switch !== 1'b1) begin errors++; $display("FAIL reset_rf_switch got %b exp 1", rf_switch); end
        checks++; if (ct_switch !== 1'b1) begin errors++; $display("FAIL reset_ct_switch got %b exp 1", ct_switch); end
        checks++; if (rx_ch_pwr_ctrl !== 3'b001) begin errors++; $display("FAIL reset_pwr_ctrl got %b exp 001", rx_ch_pwr_ctrl); end
        checks++; if (rx_ch_ctrl !== 3'b001) begin errors++; $display("FAIL reset_ch_ctrl got %b exp 001", rx_ch_ctrl); end
        checks++; if ({ad9914_load, ad9914_sweep, rx_att_load, cmd_overrun} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got %b exp 0000", {ad9914_load, ad9914_sweep, rx_att_load, cmd_overrun}); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", cmd_pending); end
        checks++; if ({rf_power, tvh} !== 2'b00) begin errors++; $display("FAIL reset_pwr_tvh got %b exp 00", {rf_power, tvh}); end
        checks++; if (tx_att !== 6'h00) begin errors++; $display("FAIL reset_tx_att got %h exp 00", tx_att); end
    endtask

    task automatic test_apply_sweep();
        depack_mode       = 3'b100;
        depack_tx_att     = 6'h15;
        depack_rf_switch  = 1'b1;
        depack_ftw_lower  = 64'h1111_2222_3333_4444;
        depack_sweep_step = 32'hDEAD_BEEF;
        send_cmd();
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL cap_pending got %b exp 1", cmd_pending); end
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL cap_overrun got %b exp 0", cmd_overrun); end
        checks++; if (tx_att !== 6'h00) begin errors++; $display("FAIL cap_not_applied got %h exp 00", tx_att); end
        tick();
        prf_rise();
        checks++; if ({ad9914_load, rx_att_load} !== 2'b11) begin errors++; $display("FAIL apply_loads got %b exp 11", {ad9914_load, rx_att_load}); end
        checks++; if (tx_att !== 6'h15) begin errors++; $display("FAIL apply_tx_att got %h exp 15", tx_att); end
        checks++; if (ftw_lower !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL apply_ftw got %h", ftw_lower); end
        checks++; if (sweep_step !== 32'hDEAD_BEEF) begin errors++; $display("FAIL apply_step got %h", sweep_step); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL apply_pending got %b exp 0", cmd_pending); end
        checks++; if (rf_switch !== 1'b0) begin errors++; $display("FAIL apply_rf_switch got %b exp 0", rf_switch); end
        checks++; if (rf_power !== 1'b1) begin errors++; $display("FAIL apply_rf_power got %b exp 1", rf_power); end
        for (int k = 2; k <= 10; k++) begin
            tick();
            checks++; if (ad9914_sweep !== (k == 9)) begin errors++; $display("FAIL settle_sweep T+%0d got %b exp %b", k, ad9914_sweep, (k == 9)); end
            checks++; if (ad9914_load !== 1'b0) begin errors++; $display("FAIL settle_load T+%0d got %b exp 0", k, ad9914_load); end
        end
        checks++; if (rx_ch_pwr_ctrl !== 3'b111) begin errors++; $display("FAIL mode_all_mask got %b exp 111", rx_ch_pwr_ctrl); end
        wait_idle();
    endtask

    task automatic test_overrun();
        depack_rx_att = 24'h00FF10;
        send_cmd();
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got %b exp 0", cmd_overrun); end
        depack_rx_att = 24'h00FF20;
        send_cmd();
        checks++; if (cmd_overrun !== 1'b1) begin errors++; $display("FAIL ovr_second got %b exp 1", cmd_overrun); end
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL ovr_pending got %b exp 1", cmd_pending); end
        tick();
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b exp 0", cmd_overrun); end
        prf_rise();
        checks++; if (ad9914_load !== 1'b1) begin errors++; $display("FAIL ovr_load got %b exp 1", ad9914_load); end
        checks++; if (rx_att !== 18'h00FE0) begin errors++; $display("FAIL ovr_rx_att got %h exp 00fe0", rx_att); end
        wait_idle();
    endtask

    task automatic test_direct_sweep();
        ct = 1'b1;
        prf_rise();
        checks++; if (ad9914_sweep !== 1'b1) begin errors++; $display("FAIL direct_sweep got %b exp 1", ad9914_sweep); end
        checks++; if ({ad9914_load, rx_att_load} !== 2'b00) begin errors++; $display("FAIL direct_no_load got %b exp 00", {ad9914_load, rx_att_load}); end
        checks++; if (ct_switch !== 1'b0) begin errors++; $display("FAIL direct_ct_switch got %b exp 0", ct_switch); end
        checks++; if (rx_ch_ctrl !== 3'b000) begin errors++; $display("FAIL direct_ch_ctrl got %b exp 000", rx_ch_ctrl); end
        checks++; if (rf_switch !== 1'b1) begin errors++; $display("FAIL direct_rf_switch got %b exp 1", rf_switch); end
        tick();
        checks++; if (ad9914_sweep !== 1'b0) begin errors++; $display("FAIL direct_sweep_once got %b exp 0", ad9914_sweep); end
        ct = 1'b0;
        prf_rise();
        wait_idle();
        checks++; if (ct_switch !== 1'b1) begin errors++; $display("FAIL direct_ct_back got %b exp 1", ct_switch); end
    endtask

    task automatic test_tvh();
        logic exp_tvh;
        depack_mode = 3'b010;
        send_cmd();
        prf_rise();
        wait_idle();
        checks++; if (rx_ch_pwr_ctrl !== 3'b011) begin errors++; $display("FAIL dual_mask got %b exp 011", rx_ch_pwr_ctrl); end
        exp_tvh = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tr_edge = 2'b10;
            tick();
            tr_edge = 2'b00;
            exp_tvh = ~exp_tvh;
            checks++; if (tvh !== exp_tvh) begin errors++; $display("FAIL tvh_toggle %0d got %b exp %b", i, tvh, exp_tvh); end
            if (i == 0) begin
                checks++; if (rf_power !== 1'b0) begin errors++; $display("FAIL tr_fall_power got %b exp 0", rf_power); end
            end
            tick();
        end
        prf_edge = 2'b01;
        tr_edge  = 2'b10;
        tick();
        prf_edge = 2'b00;
        tr_edge  = 2'b00;
        checks++; if (rf_power !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", rf_power); end
        checks++; if (tvh !== 1'b1) begin errors++; $display("FAIL tvh_fifth got %b exp 1", tvh); end
        wait_idle();
        depack_mode = 3'b000;
        send_cmd();
        prf_rise();
        wait_idle();
        checks++; if (rx_ch_pwr_ctrl !== 3'b001) begin errors++; $display("FAIL single_mask got %b exp 001", rx_ch_pwr_ctrl); end
        tr_edge = 2'b10;
        tick();
        tr_edge = 2'b00;
        checks++; if (tvh !== 1'b0) begin errors++; $display("FAIL tvh_forced got %b exp 0", tvh); end
    endtask

    task automatic test_back_to_back();
        depack_tx_att = 6'h01;
        send_cmd();
        depack_tx_att = 6'h02;
        update_cmd = 1'b1;
        prf_edge   = 2'b01;
        tick();
        update_cmd = 1'b0;
        prf_edge   = 2'b00;
        checks++; if (ad9914_load !== 1'b1) begin errors++; $display("FAIL b2b_load got %b exp 1", ad9914_load); end
        checks++; if (tx_att !== 6'h01) begin errors++; $display("FAIL b2b_old_applied got %h exp 01", tx_att); end
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got %b exp 1", cmd_pending); end
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b exp 0", cmd_overrun); end
        wait_idle();
        prf_rise();
        checks++; if (tx_att !== 6'h02) begin errors++; $display("FAIL b2b_new_applied got %h exp 02", tx_att); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL b2b_cleared got %b exp 0", cmd_pending); end
        wait_idle();
        depack_tx_att = 6'h03;
        update_cmd = 1'b1;
        prf_edge   = 2'b01;
        tick();
        update_cmd = 1'b0;
        prf_edge   = 2'b00;
        checks++; if ({ad9914_sweep, ad9914_load} !== 2'b10) begin errors++; $display("FAIL b2b_idle_sweep got %b exp 10", {ad9914_sweep, ad9914_load}); end
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL b2b_idle_pending got %b exp 1", cmd_pending); end
        checks++; if (tx_att !== 6'h02) begin errors++; $display("FAIL b2b_idle_no_apply got %h exp 02", tx_att); end
        wait_idle();
        prf_rise();
        wait_idle();
    endtask

    task automatic test_reset_mid();
        depack_tx_att = 6'h2A;
        send_cmd();
        prf_rise();
        tick();
        tick();
        depack_tx_att = 6'h0B;
        send_cmd();
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", cmd_pending); end
        rst = 1'b1;
        tick();
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL mid_rst_pending got %b exp 0", cmd_pending); end
        checks++; if (tx_att !== 6'h00) begin errors++; $display("FAIL mid_rst_tx_att got %h exp 00", tx_att); end
        checks++; if ({rf_switch, ct_switch, rf_power} !== 3'b110) begin errors++; $display("FAIL mid_rst_ctrl got %b exp 110", {rf_switch, ct_switch, rf_power}); end
        checks++; if (rx_ch_pwr_ctrl !== 3'b001) begin errors++; $display("FAIL mid_rst_mask got %b exp 001", rx_ch_pwr_ctrl); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++; if (ad9914_sweep !== 1'b0) begin errors++; $display("FAIL mid_no_sweep cyc %0d got %b exp 0", k, ad9914_sweep); end
            tick();
        end
    endtask

    initial begin
        rst               = 1'b1;
        update_cmd        = 1'b0;
        tr_edge           = 2'b00;
        prf_edge          = 2'b00;
        ct                = 1'b0;
        depack_mode       = 3'b000;
        depack_rf_switch  = 1'b0;
        depack_tx_att     = '0;
        depack_rx_att     = '0;
        depack_rx_pha     = '0;
        depack_ftw_lower  = '0;
        depack_ftw_upper  = '0;
        depack_sweep_step = '0;
        depack_sweep_rate = '0;
        test_reset();
        test_apply_sweep();
        test_overrun();
        test_direct_sweep();
        test_tvh();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
